counter_updown: RTL and testbench

Parametrised up/down counter with synchronous load, programmable inclusive upper limit, variable step, and selectable wrap or saturate behaviour. It is the general-purpose counting primitive of the memory/arithmetics library and replaces the fixed increment-by-one load counter. Typical uses are address generators, timers, and modulo sequencers.

---
 rtl/counter_updown.sv | 114 +++++++++++
 tb/tb_counter_updown.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_updown.sv
// counter_updown: up/down counter with synchronous load, inclusive upper
// limit, variable step and selectable wrap-modulo-(lim+1) or saturate
// behaviour. o, wrap and ovf are registered; tc is decoded from o.
module counter_updown #(
    parameter int BUS_WIDTH   = 8,
    parameter int STEP_WIDTH  = 4,
    parameter bit SATURATE    = 1'b0,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic [BUS_WIDTH-1:0]  X,
    input  logic                  en,
    input  logic                  up,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [BUS_WIDTH-1:0]  lim,
    output logic [BUS_WIDTH-1:0]  o,
    output logic                  tc,
    output logic                  wrap,
    output logic                  ovf
);

    // Two extra bits: one for the carry of o+step, one so lim+1 never
    // overflows when lim is all-ones (full 2^BUS_WIDTH range).
    localparam int IW = BUS_WIDTH + 2;
    localparam logic [BUS_WIDTH-1:0] RST_VAL = BUS_WIDTH'(RESET_VALUE);

    logic [BUS_WIDTH-1:0] o_reg, o_next;
    logic                 wrap_reg, wrap_next;
    logic                 ovf_reg, ovf_next;

    logic [IW-1:0] o_ext, lim_ext, step_ext, lim_p1;
    logic [IW-1:0] sum, up_rem, dn_def;
    logic [BUS_WIDTH-1:0] dn_diff, dn_wrap;
    logic [BUS_WIDTH-1:0] load_val;

    assign o_ext    = {2'b00, o_reg};
    assign lim_ext  = {2'b00, lim};
    assign step_ext = IW'(step);
    assign lim_p1   = lim_ext + IW'(1);

    // Up path: raw sum and the remainder after folding past lim.
    assign sum    = o_ext + step_ext;
    assign up_rem = sum - lim_p1;

    // Down path: plain difference, and the shortfall below zero (d).
    // When d <= lim+1 the wrapped value lim+1-d always fits BUS_WIDTH bits.
    assign dn_diff = o_reg - step_ext[BUS_WIDTH-1:0];
    assign dn_def  = step_ext - o_ext;
    assign dn_wrap = lim - dn_def[BUS_WIDTH-1:0] + BUS_WIDTH'(1);

    // Load value is clamped into the legal range [0, lim].
    assign load_val = (X > lim) ? lim : X;

    // Next-state for an enabled count; holds otherwise.
    always_comb begin
        o_next    = o_reg;
        wrap_next = 1'b0;
        ovf_next  = ovf_reg;
        if (en && (step != '0)) begin
            if (up) begin
                if (sum <= lim_ext) begin
                    o_next = sum[BUS_WIDTH-1:0];
                end else begin
                    wrap_next = 1'b1;
                    if (SATURATE)
                        o_next = lim;
                    else if (up_rem <= lim_ext)
                        o_next = up_rem[BUS_WIDTH-1:0];
                    else
                        o_next = '0;
                end
            end else begin
                if (o_ext >= step_ext) begin
                    o_next = dn_diff;
                end else begin
                    wrap_next = 1'b1;
                    if (SATURATE)
                        o_next = '0;
                    else if (dn_def <= lim_p1)
                        o_next = dn_wrap;
                    else
                        o_next = lim;
                end
            end
            if (wrap_next)
                ovf_next = 1'b1;
        end
    end

    // State register with priority rst > st > count/hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_reg    <= RST_VAL;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (st) begin
            o_reg    <= load_val;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            o_reg    <= o_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign o    = o_reg;
    assign wrap = wrap_reg;
    assign ovf  = ovf_reg;
    assign tc   = up ? (o_reg == lim) : (o_reg == '0);

endmodule

// File: tb/tb_counter_updown.sv
// Testbench for counter_updown: one wrap-mode instance (RESET_VALUE=5) and
// one saturate-mode instance share all inputs; both are compared each cycle
// against an integer reference model derived from the counting rules.
module tb_counter_updown;

    logic       clk = 1'b0;
    logic       rst, st, en, up;
    logic [7:0] X, lim;
    logic [3:0] step;

    logic [7:0] o_w, o_s;
    logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: index 0 = wrap instance, 1 = saturate instance.
    int mo[2];
    bit mw[2];
    bit mf[2];
    bit mvalid = 1'b0;

    always #5 clk = ~clk;

    counter_updown #(.BUS_WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(5)) u_wrap (
        .clk(clk), .rst(rst), .st(st), .X(X), .en(en), .up(up), .step(step),
        .lim(lim), .o(o_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
    );

    counter_updown #(.BUS_WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
        .clk(clk), .rst(rst), .st(st), .X(X), .en(en), .up(up), .step(step),
        .lim(lim), .o(o_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counting rules applied with plain integer arithmetic.
    task automatic model_edge();
        int s;
        int r;
        int d;
        int l;
        bit ev;
        l = int'(lim);
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0;
            if (rst) begin
                mo[k] = (k == 0) ? 5 : 0;
                mf[k] = 1'b0;
            end else if (st) begin
                mo[k] = (int'(X) > l) ? l : int'(X);
                mf[k] = 1'b0;
            end else if (en && step != 0) begin
                ev = 1'b1;
                if (up) begin
                    s = mo[k] + int'(step);
                    if (s <= l) begin
                        mo[k] = s;
                        ev = 1'b0;
                    end else if (k == 1) begin
                        mo[k] = l;
                    end else begin
                        r = s - (l + 1);
                        mo[k] = (r <= l) ? r : 0;
                    end
                end else begin
                    if (mo[k] >= int'(step)) begin
                        mo[k] = mo[k] - int'(step);
                        ev = 1'b0;
                    end else if (k == 1) begin
                        mo[k] = 0;
                    end else begin
                        d = int'(step) - mo[k];
                        mo[k] = (d <= l + 1) ? (l + 1 - d) : l;
                    end
                end
            end
            mw[k] = ev;
            if (ev)
                mf[k] = 1'b1;
        end
    endtask

    function automatic logic exp_tc(input int k);
        return up ? (mo[k] == int'(lim)) : (mo[k] == 0);
    endfunction

    // One clock cycle: drive inputs, check tc combinationally, clock, check.
    task automatic cyc(input logic r, input logic s, input logic [7:0] x,
                       input logic e, input logic u, input logic [3:0] stp,
                       input logic [7:0] l);
        rst = r; st = s; X = x; en = e; up = u; step = stp; lim = l;
        #1;
        if (mvalid) begin
            chk("tc_w_pre", 32'(tc_w), 32'(exp_tc(0)));
            chk("tc_s_pre", 32'(tc_s), 32'(exp_tc(1)));
        end
        @(posedge clk);
        model_edge();
        mvalid = 1'b1;
        #1;
        chk("o_w",    32'(o_w),    32'(mo[0]));
        chk("wrap_w", 32'(wrap_w), 32'(mw[0]));
        chk("ovf_w",  32'(ovf_w),  32'(mf[0]));
        chk("tc_w",   32'(tc_w),   32'(exp_tc(0)));
        chk("o_s",    32'(o_s),    32'(mo[1]));
        chk("wrap_s", 32'(wrap_s), 32'(mw[1]));
        chk("ovf_s",  32'(ovf_s),  32'(mf[1]));
        chk("tc_s",   32'(tc_s),   32'(exp_tc(1)));
        $display("t=%0t rst=%0d st=%0d X=%0d en=%0d up=%0d step=%0d lim=%0d | o_w=%0d wr=%0d ov=%0d | o_s=%0d wr=%0d ov=%0d",
                 $time, r, s, x, e, u, stp, l, o_w, wrap_w, ovf_w, o_s, wrap_s, ovf_s);
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; X = '0; en = 1'b0; up = 1'b1; step = '0; lim = 8'd9;

        // Reset beats load and count.
        cyc(1, 1, 8'd3, 1, 1, 4'd1, 8'd9);
        cyc(1, 1, 8'd3, 1, 1, 4'd1, 8'd9);
        chk("plan_rst_o", 32'(o_w), 32'd5);
        chk("plan_rst_wrap", 32'(wrap_w), 32'd0);
        cyc(0, 0, 8'd3, 1, 1, 4'd1, 8'd9);
        chk("plan_rst_resume", 32'(o_w), 32'd6);

        // Modulo-10 count from 0.
        cyc(0, 1, 8'd0, 0, 1, 4'd1, 8'd9);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 8'd0, 1, 1, 4'd1, 8'd9);
            if (i == 9) begin
                chk("plan_mod10_o", 32'(o_w), 32'd0);
                chk("plan_mod10_wrap", 32'(wrap_w), 32'd1);
            end
        end
        chk("plan_mod10_ovf", 32'(ovf_w), 32'd1);

        // Large-step wrap up and down, including d > lim+1.
        cyc(0, 1, 8'd8, 0, 1, 4'd3, 8'd9);
        cyc(0, 0, 8'd0, 1, 1, 4'd3, 8'd9);
        chk("plan_big_up", 32'(o_w), 32'd1);
        cyc(0, 0, 8'd0, 1, 0, 4'd3, 8'd9);
        chk("plan_big_dn", 32'(o_w), 32'd8);
        cyc(0, 1, 8'd1, 0, 0, 4'd12, 8'd9);
        cyc(0, 0, 8'd0, 1, 0, 4'd12, 8'd9);
        chk("plan_big_d", 32'(o_w), 32'd9);

        // Saturate at upper bound, re-asserting wrap; then at zero.
        cyc(0, 1, 8'd196, 0, 1, 4'd7, 8'd200);
        cyc(0, 0, 8'd0, 1, 1, 4'd7, 8'd200);
        chk("plan_sat_hi", 32'(o_s), 32'd200);
        cyc(0, 0, 8'd0, 1, 1, 4'd7, 8'd200);
        chk("plan_sat_again", 32'(wrap_s), 32'd1);
        cyc(0, 1, 8'd5, 0, 0, 4'd7, 8'd200);
        cyc(0, 0, 8'd0, 1, 0, 4'd7, 8'd200);
        chk("plan_sat_lo", 32'(o_s), 32'd0);

        // Load clamp beats enable; plain load.
        cyc(0, 1, 8'd250, 1, 1, 4'd1, 8'd100);
        chk("plan_clamp", 32'(o_w), 32'd100);
        cyc(0, 1, 8'd40, 1, 1, 4'd1, 8'd100);
        chk("plan_load", 32'(o_w), 32'd40);

        // Holds, then full-range wrap with lim=255.
        cyc(0, 0, 8'd0, 1, 1, 4'd0, 8'd100);
        cyc(0, 0, 8'd0, 0, 1, 4'd5, 8'd100);
        chk("plan_hold", 32'(o_w), 32'd40);
        cyc(0, 1, 8'd250, 0, 1, 4'd9, 8'd255);
        cyc(0, 0, 8'd0, 1, 1, 4'd9, 8'd255);
        chk("plan_full", 32'(o_w), 32'd3);

        // Randomized traffic, including lim moving below o.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] nl;
            case ($urandom_range(0, 3))
                0:       nl = 8'd255;
                1:       nl = 8'd9;
                2:       nl = 8'($urandom);
                default: nl = lim;
            endcase
            cyc(($urandom % 60) == 0, ($urandom % 12) == 0, 8'($urandom),
                ($urandom % 4) != 0, 1'($urandom), 4'($urandom), nl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
